sdram_wr_burst: RTL and testbench
=================================

SDRAM_WR_BURST -- requirements
Module: sdram_wr_burst

Interface
REQ-001 Parameter BURST_LEN, default 8: words per SDRAM write burst; legal values 2..16.
REQ-002 Parameter DATAWIDTH, default 16: SDRAM data word width in bits.
REQ-003 Port sdram_clk, input, 1: the single clock; every flop is on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset; the only clock and reset of the block.
REQ-005 Port wr_start, input, 1: single-cycle pulse that requests one burst.
REQ-006 Port wr_start_addr, input, 24: byte address sampled when wr_start is accepted.
REQ-007 Port in_data, input, DATAWIDTH: payload word from the upstream write-data path.
REQ-008 Port in_valid, input, 1: in_data is valid.
REQ-009 Port in_ready, output, 1: block accepts in_data.
REQ-010 Port wr_addr, output, 24: word address presented to the SDRAM controller.
REQ-011 Port wr_avalid, output, 1: wr_addr is valid.
REQ-012 Port wr_aready, input, 1: SDRAM controller accepts the address.
REQ-013 Port wr_data, output, DATAWIDTH: data word presented to the SDRAM controller.
REQ-014 Port wr_valid, output, 1: wr_data is valid.
REQ-015 Port wr_ready, input, 1: SDRAM controller accepts the data word.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.
REQ-017 Port done, output, 1: one-cycle pulse after the last data beat is accepted.

Function
REQ-018 States: IDLE, FILL, ADDR, DATA, DONE.
REQ-019 IDLE: wr_start=1 latches the address and moves to FILL; wr_start is ignored in every other state.
REQ-020 FILL: in_ready=1; each in_valid&&in_ready beat writes buffer[fill_cnt] and increments fill_cnt; the beat at fill_cnt==BURST_LEN-1 moves to ADDR; in_ready=0 in all other states.
REQ-021 ADDR: wr_avalid=1; wr_avalid&&wr_aready moves to DATA; wr_addr holds stable while wr_avalid=1.
REQ-022 DATA: wr_valid=1 and wr_data=buffer[drain_cnt]; wr_valid&&wr_ready increments drain_cnt; the beat at drain_cnt==BURST_LEN-1 moves to DONE; wr_data holds stable while wr_ready=0.
REQ-023 DONE: done=1 for exactly one cycle, then return to IDLE; fill_cnt and drain_cnt are cleared to 0.
REQ-024 Minimum latency: with in_valid, wr_aready and wr_ready tied high, the path wr_start -> FILL -> ADDR -> DATA -> DONE -> IDLE takes 2*BURST_LEN+3 cycles.
REQ-025 Counters are $clog2(BURST_LEN)+1 bits wide and never wrap within a burst; extra in_valid beats after FILL are not accepted (in_ready=0).
REQ-026 wr_start arriving in the same cycle as done is ignored; wr_start is accepted no earlier than the next cycle.

Reset
REQ-027 While rst_n=0: state=IDLE, counters=0, wr_addr=0, and in_ready, wr_avalid, wr_valid, busy and done are all 0; wr_data=0.
REQ-028 Reset asserted mid-burst abandons the burst immediately; the buffer contents are don't-care; no done pulse is produced.

Configuration
REQ-029 Macro SDRAM_WR_ADDR_WORD_EN defined: wr_addr = {1'b0, wr_start_addr[23:1]} (byte address to 16-bit word address).
REQ-030 Macro SDRAM_WR_ADDR_WORD_EN undefined: wr_addr = wr_start_addr[23:0] unchanged.

Structure
REQ-031 Shared package sdram_wr_pkg holds the state encoding constants (3-bit: IDLE=0, FILL=1, ADDR=2, DATA=3, DONE=4) and the default BURST_LEN.
REQ-032 Sub-module wr_burst_buf is a BURST_LEN x DATAWIDTH register file with a synchronous write and a combinational read, reset-free; it is instantiated once.

Verification
REQ-033 wr_start with addr 0x000010 (macro defined), 8 words 0x1111..0x8888 streamed, readies high -> wr_addr=0x000008, 8 beats 0x1111..0x8888 in order, done at cycle 19.
REQ-034 Same stimulus with the macro undefined -> wr_addr=0x000010.
REQ-035 wr_aready held low 5 cycles, wr_ready toggled every other cycle -> wr_addr and wr_data stable while stalled, no beat lost or duplicated, exactly one done.
REQ-036 in_valid gapped (1 of 3 cycles) and a 9th word offered -> the 9th word is refused (in_ready=0), exactly 8 beats written.
REQ-037 Second wr_start during DATA, and another in the done cycle -> both ignored; a wr_start one cycle after done starts a new burst.
REQ-038 rst_n pulsed low during DATA beat 4 -> all outputs 0 asynchronously, no done, and the next burst completes normally.

Source files
------------

// File: rtl/sdram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wr_pkg
// Purpose  : Shared definitions for the SDRAM write-burst block: the 3-bit
//            state encoding, the default burst length and a helper that
//            sizes the beat counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sdram_wr_pkg;

  localparam int BURST_LEN_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // One bit wider than the index so a counter can reach BURST_LEN
  // without wrapping.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wr_burst_buf.sv
`default_nettype none
// ============================================================================
// Module   : wr_burst_buf
// Purpose  : DEPTH x DATAWIDTH register file holding one write burst.
//            Synchronous write, combinational read, no reset (contents are
//            always written before they are read).
// Ports    : clk     - clock, rising edge
//            i_we    - write enable
//            i_waddr - write index
//            i_wdata - write data
//            i_raddr - read index
//            o_rdata - read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module wr_burst_buf
  import sdram_wr_pkg::*;
#(
  parameter int DEPTH     = BURST_LEN_DEF,
  parameter int DATAWIDTH = 16,
  parameter int AW        = $clog2(BURST_LEN_DEF)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DATAWIDTH-1:0] o_rdata
);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sdram_wr_burst.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wr_burst
// Purpose  : Collects BURST_LEN words from an upstream valid/ready stream,
//            then issues one address and BURST_LEN data beats to an SDRAM
//            controller, pulsing done once the last beat is accepted.
// Macro    : SDRAM_WR_ADDR_WORD_EN - when defined, the byte start address is
//            converted to a 16-bit word address (shifted right by one);
//            when undefined the start address is passed through unchanged.
// Ports    : sdram_clk     - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            wr_start      - one-cycle burst request (IDLE only)
//            wr_start_addr - byte start address, latched on wr_start
//            in_data/in_valid/in_ready - upstream payload stream
//            wr_addr/wr_avalid/wr_aready - address channel to controller
//            wr_data/wr_valid/wr_ready   - data channel to controller
//            busy          - state is not IDLE
//            done          - one-cycle pulse after the final data beat
// Revision : 1.0 - initial release
// ============================================================================
module sdram_wr_burst
  import sdram_wr_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int DATAWIDTH = 16
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,
  input  logic                 wr_start,
  input  logic [23:0]          wr_start_addr,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [23:0]          wr_addr,
  output logic                 wr_avalid,
  input  logic                 wr_aready,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = cnt_width(BURST_LEN);
  localparam int AW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] C_LAST = CW'(BURST_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_fill_cnt;
  logic [CW-1:0]        r_drain_cnt;
  logic [23:0]          r_addr;
  logic [23:0]          w_addr_in;
  logic                 w_fill_beat;
  logic                 w_drain_beat;
  logic [DATAWIDTH-1:0] w_buf_rdata;

`ifdef SDRAM_WR_ADDR_WORD_EN
  // The byte-lane bit is dropped by the word conversion.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = wr_start_addr[0];
  assign w_addr_in         = {1'b0, wr_start_addr[23:1]};
`else
  assign w_addr_in = wr_start_addr;
`endif

  assign w_fill_beat  = in_valid && in_ready;
  assign w_drain_beat = wr_valid && wr_ready;

  // State register
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    wr_avalid   = 1'b0;
    wr_valid    = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (wr_start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (r_fill_cnt == C_LAST)) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        wr_avalid = 1'b1;
        if (wr_aready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        wr_valid = 1'b1;
        if (wr_ready && (r_drain_cnt == C_LAST)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat counters; cleared in DONE so the next burst starts at index 0.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (r_state == S_DONE) begin
      r_fill_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_fill_beat)  r_fill_cnt  <= r_fill_cnt + CW'(1);
      if (w_drain_beat) r_drain_cnt <= r_drain_cnt + CW'(1);
    end
  end

  // Address is captured only on an accepted start, so it stays put for the
  // whole burst including the address handshake.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if ((r_state == S_IDLE) && wr_start) begin
      r_addr <= w_addr_in;
    end
  end

  assign wr_addr = r_addr;

  wr_burst_buf #(
    .DEPTH     (BURST_LEN),
    .DATAWIDTH (DATAWIDTH),
    .AW        (AW)
  ) u_buf (
    .clk     (sdram_clk),
    .i_we    (w_fill_beat),
    .i_waddr (r_fill_cnt[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_drain_cnt[AW-1:0]),
    .o_rdata (w_buf_rdata)
  );

  // The buffer has no reset, so the data bus is forced to zero outside DATA.
  assign wr_data = wr_valid ? w_buf_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_wr_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_wr_burst
// Purpose  : Self-checking bench for sdram_wr_burst. A transaction-level
//            model (counts of words taken, address accepted, words drained)
//            predicts every output each cycle; a scoreboard compares the
//            beats emitted against the words streamed in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_wr_burst;

  localparam int B  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0;
  logic [23:0]   wr_start_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [23:0]   wr_addr;
  logic          wr_avalid;
  logic          wr_aready = 1'b0;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sdram_wr_burst #(.BURST_LEN(B), .DATAWIDTH(DW)) dut (
    .sdram_clk     (clk),
    .rst_n         (rst_n),
    .wr_start      (wr_start),
    .wr_start_addr (wr_start_addr),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_addr       (wr_addr),
    .wr_avalid     (wr_avalid),
    .wr_aready     (wr_aready),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .done          (done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_active;
  int            m_acc;
  bit            m_aok;
  int            m_drn;
  logic [23:0]   m_addr;
  logic [DW-1:0] m_buf [B];

  logic [DW-1:0] words [B];
  logic [DW-1:0] got [$];
  int            done_cnt;

  typedef struct {
    logic [23:0] addr;
    int          gap;
    int          stall;
    int          rmode;
    bit          extra;
    logic [23:0] exp_addr;
    int          exp_done;
  } vec_t;

  vec_t vt [4];

  function automatic logic [23:0] map_addr(input logic [23:0] a);
`ifdef SDRAM_WR_ADDR_WORD_EN
    return a >> 1;
`else
    return a;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_acc = 0; m_aok = 0; m_drn = 0; m_addr = '0;
  endtask

  // Advance the model by one clock using the inputs presented at the edge.
  task automatic model_edge();
    if (!m_active) begin
      if (wr_start) begin
        m_active = 1; m_acc = 0; m_aok = 0; m_drn = 0;
        m_addr = map_addr(wr_start_addr);
      end
    end else if (m_drn == B) begin
      m_active = 0;
    end else if (m_acc < B) begin
      if (in_valid) begin
        m_buf[m_acc] = in_data;
        m_acc++;
      end
    end else if (!m_aok) begin
      if (wr_aready) m_aok = 1;
    end else if (wr_ready) begin
      m_drn++;
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] e_d;
    bit e_v;
    e_v = m_active && m_aok && (m_drn < B);
    e_d = '0;
    if (e_v) e_d = m_buf[m_drn];
    check("busy",      busy,      m_active);
    check("in_ready",  in_ready,  m_active && (m_acc < B));
    check("wr_avalid", wr_avalid, m_active && (m_acc == B) && !m_aok);
    check("wr_valid",  wr_valid,  e_v);
    check("done",      done,      m_active && (m_drn == B));
    check("wr_addr",   wr_addr,   m_addr);
    check("wr_data",   wr_data,   e_d);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic step();
    if (wr_valid === 1'b1 && wr_ready === 1'b1) got.push_back(wr_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_wr_avalid"}, wr_avalid, 0);
    check({tag, "_wr_valid"},  wr_valid,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_wr_addr"},   wr_addr,   0);
    check({tag, "_wr_data"},   wr_data,   0);
  endtask

  // Called at a negedge; asserts reset between edges and releases it one
  // cycle later, also between edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  // smode: 0 no extra starts, 1 random starts during burst,
  //        2 starts during DATA beat 2 and in the done cycle.
  // rmode: 0 wr_ready high, 1 toggling, 2 random.
  task automatic run_burst(input logic [23:0] addr, input int gap, input int stall,
                           input int rmode, input bit extra, input int smode,
                           input bit abort, output int done_cyc);
    int cyc;
    int st;
    bit aborted;
    got.delete();
    done_cnt = 0; done_cyc = 0; st = 0; aborted = 0;
    wr_start = 1'b1; wr_start_addr = addr;
    in_valid = 1'b0; wr_aready = 1'b0; wr_ready = 1'b0;
    step();
    cyc = 1;
    while (done_cnt == 0 && cyc < 400 && !aborted) begin
      if (abort && m_aok && m_drn == 4) begin
        reset_pulse();
        aborted = 1;
      end else begin
        wr_start_addr = 24'($urandom);
        case (smode)
          1:       wr_start = ($urandom_range(0, 3) == 0);
          2:       wr_start = m_aok && (m_drn == 2);
          default: wr_start = 1'b0;
        endcase
        in_valid = ((cyc % gap) == 0) && ((m_acc < B) || extra);
        if (m_acc < B) in_data = words[m_acc];
        else           in_data = 16'hBEEF;
        if (m_active && m_acc == B && !m_aok) begin
          wr_aready = (st >= stall);
          st++;
        end else begin
          wr_aready = 1'($urandom_range(0, 1));
        end
        case (rmode)
          0:       wr_ready = 1'b1;
          1:       wr_ready = cyc[0];
          default: wr_ready = 1'($urandom_range(0, 1));
        endcase
        step();
        cyc++;
        if (done_cnt != 0) done_cyc = cyc + 1;
      end
    end
    if (aborted) begin
      wr_start = 1'b0; in_valid = 1'b0;
      return;
    end
    // Return to IDLE; in smode 2 a start in the done cycle must be ignored.
    wr_start = (smode == 2);
    in_valid = extra;
    step();
    wr_start = 1'b0;
    in_valid = 1'b0;
    check("done_count", done_cnt, 1);
    check("beat_count", got.size(), B);
    for (int k = 0; k < B && k < got.size(); k++)
      check($sformatf("beat%0d", k), got[k], words[k]);
  endtask

  initial begin
    int dc;

    vt[0] = '{24'h000010, 1, 0, 0, 1'b0, 24'h000000, 2 * B + 3};
    vt[1] = '{24'hABCDEF, 1, 5, 1, 1'b0, 24'h000000, 0};
    vt[2] = '{24'h000123, 3, 0, 0, 1'b1, 24'h000000, 0};
    vt[3] = '{24'hFFFFFE, 2, 2, 2, 1'b1, 24'h000000, 0};
`ifdef SDRAM_WR_ADDR_WORD_EN
    vt[0].exp_addr = 24'h000008;
    vt[1].exp_addr = 24'h55E6F7;
    vt[2].exp_addr = 24'h000091;
    vt[3].exp_addr = 24'h7FFFFF;
`else
    vt[0].exp_addr = 24'h000010;
    vt[1].exp_addr = 24'hABCDEF;
    vt[2].exp_addr = 24'h000123;
    vt[3].exp_addr = 24'hFFFFFE;
`endif

    // Power-on reset
    model_reset();
    #3 check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // Table-driven bursts
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < B; k++)
        words[k] = (i == 0) ? DW'(16'h1111 * (k + 1)) : DW'($urandom);
      run_burst(vt[i].addr, vt[i].gap, vt[i].stall, vt[i].rmode, vt[i].extra, 0, 0, dc);
      check($sformatf("tbl%0d_wr_addr", i), wr_addr, vt[i].exp_addr);
      if (vt[i].exp_done != 0)
        check($sformatf("tbl%0d_done_cycle", i), dc, vt[i].exp_done);
    end

    // Starts during DATA and in the done cycle are ignored; the next cycle
    // starts a fresh burst.
    for (int k = 0; k < B; k++) words[k] = DW'($urandom);
    run_burst(24'h00ABCD, 1, 1, 0, 1'b0, 2, 0, dc);
    for (int k = 0; k < B; k++) words[k] = DW'($urandom);
    run_burst(24'h001234, 1, 0, 0, 1'b0, 0, 0, dc);
    check("restart_done_cycle", dc, 2 * B + 3);

    // Reset during DATA beat 4, then a normal burst
    for (int k = 0; k < B; k++) words[k] = DW'($urandom);
    run_burst(24'h0F0F0F, 1, 0, 0, 1'b0, 0, 1, dc);
    check("abort_no_done", done_cnt, 0);
    @(negedge clk);
    compare_all();
    check("abort_no_done_after", done_cnt, 0);
    for (int k = 0; k < B; k++) words[k] = DW'($urandom);
    run_burst(24'h000010, 1, 0, 0, 1'b0, 0, 0, dc);
    check("post_reset_done_cycle", dc, 2 * B + 3);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < B; k++) words[k] = DW'($urandom);
      run_burst(24'($urandom), $urandom_range(1, 3), $urandom_range(0, 4), 2,
                1'($urandom_range(0, 1)), 1, 0, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
